// File: rtl/bsr_seq.sv
// bsr_seq -- sequential right-rotate unit, the inverse of the left barrel
// rotator bs. A START command captures DIN and SEL. The working word is then
// rotated by one bit per clock until SEL steps are done. The result appears
// on DOUT with a one-cycle DONE pulse and is held until the next result.
//
// Optional feature macro: BSR_DIR_EN. When it is defined, a DIR input is
// added and captured with START: 0 = rotate right, 1 = rotate left.
//
// Parameters:
//   WIDTH  data width, must equal 2**SELW
//   SELW   width of the rotate amount
// Ports:
//   CLK    clock, rising edge
//   RST    synchronous active-high reset
//   START  command strobe, sampled in IDLE and DONE only
//   SEL    rotate amount 0..WIDTH-1, captured with START
//   DIN    word to rotate, captured with START
//   DIR    direction (BSR_DIR_EN only), captured with START
//   DOUT   registered result, changes only on entry to DONE
//   BUSY   high while rotation steps are in progress
//   DONE   one-cycle pulse, DOUT valid in the same cycle
module bsr_seq #(
  parameter int WIDTH = 4,
  parameter int SELW  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [SELW-1:0]  SEL,
  input  logic [WIDTH-1:0] DIN,
`ifdef BSR_DIR_EN
  input  logic             DIR,
`endif
  output logic [WIDTH-1:0] DOUT,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  w;
  logic [SELW-1:0]   cnt;
  logic [WIDTH-1:0]  w_step;
`ifdef BSR_DIR_EN
  logic              dir_q;
`endif

  function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
    return {x[0], x[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  // One rotation step of the working word in the captured direction.
  always_comb begin
    w_step = rotr1(w);
`ifdef BSR_DIR_EN
    if (dir_q) w_step = rotl1(w);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      w     <= '0;
      cnt   <= '0;
      DOUT  <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef BSR_DIR_EN
      dir_q <= 1'b0;
`endif
    end else begin
      case (state)
        // IDLE and DONE both accept a command, so back-to-back starts
        // lose no cycle.
        ST_IDLE, ST_DONE: begin
          DONE <= 1'b0;
          BUSY <= 1'b0;
          if (START) begin
            w   <= DIN;
            cnt <= SEL;
`ifdef BSR_DIR_EN
            dir_q <= DIR;
`endif
            if (SEL != '0) begin
              state <= ST_SHIFT;
              BUSY  <= 1'b1;
            end else begin
              // Zero rotation goes straight to DONE, so CNT never
              // decrements from 0.
              state <= ST_DONE;
              DONE  <= 1'b1;
              DOUT  <= DIN;
            end
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          w   <= w_step;
          cnt <= cnt - SELW'(1);
          if (cnt == SELW'(1)) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            DOUT  <= w_step;
          end
        end

        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsr_seq.sv
module tb_bsr_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [1:0] SEL = 2'd0;
  logic [3:0] DIN = 4'd0;
  logic       dir_t = 1'b0;
  logic [3:0] DOUT;
  logic       BUSY;
  logic       DONE;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  bsr_seq #(.WIDTH(4), .SELW(2)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SEL   (SEL),
    .DIN   (DIN),
`ifdef BSR_DIR_EN
    .DIR   (dir_t),
`endif
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rotl4(input int x, input int s);
    return ((x << s) | (x >> (4 - s))) & 15;
  endfunction

  function automatic int rotr4(input int x, input int s);
    return ((x >> s) | (x << (4 - s))) & 15;
  endfunction

  // Transaction-level model: m_left = -1 idle, 0 in the DONE cycle,
  // >0 rotation cycles still to go.
  int  m_left = -1;
  int  m_pend = 0;
  int  m_dout = 0;
  bit  m_valid = 0;

  always @(posedge CLK) begin
    if (RST) begin
      m_left  = -1;
      m_dout  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_left > 0) begin
        m_left = m_left - 1;
      end else if (START) begin
        m_left = int'(SEL);
        m_pend = dir_t ? rotl4(int'(DIN), int'(SEL)) : rotr4(int'(DIN), int'(SEL));
      end else begin
        m_left = -1;
      end
      if (m_left == 0) m_dout = m_pend;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      check("m_busy", {31'd0, BUSY}, (m_left > 0) ? 32'd1 : 32'd0);
      check("m_done", {31'd0, DONE}, (m_left == 0) ? 32'd1 : 32'd0);
      check("m_dout", {28'd0, DOUT}, m_dout);
    end
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic outs(input string name, input logic [3:0] d, input logic b, input logic dn);
    check({name, "_dout"}, {28'd0, DOUT}, {28'd0, d});
    check({name, "_busy"}, {31'd0, BUSY}, {31'd0, b});
    check({name, "_done"}, {31'd0, DONE}, {31'd0, dn});
  endtask

  initial begin
    int got;
    // Reset held with START high: nothing accepted.
    RST = 1'b1; START = 1'b1; SEL = 2'd1; DIN = 4'hF;
    tick; outs("rst1", 4'h0, 1'b0, 1'b0);
    tick; outs("rst2", 4'h0, 1'b0, 1'b0);
    RST = 1'b0; START = 1'b0;
    tick; outs("idle", 4'h0, 1'b0, 1'b0);

    // SEL=1, DIN=0011 -> 1001 after 2 cycles.
    SEL = 2'd1; DIN = 4'b0011; START = 1'b1;
    tick; START = 1'b0; outs("s1_k1", 4'h0, 1'b1, 1'b0);
    tick; outs("s1_k2", 4'b1001, 1'b0, 1'b1);
    tick; outs("s1_hold", 4'b1001, 1'b0, 1'b0);

    // SEL=0, DIN=1010 -> immediate DONE.
    SEL = 2'd0; DIN = 4'b1010; START = 1'b1;
    tick; START = 1'b0; outs("s0_k1", 4'b1010, 1'b0, 1'b1);
    tick; outs("s0_hold", 4'b1010, 1'b0, 1'b0);

    // SEL=3, DIN=1100 -> 1001; START during SHIFT ignored.
    SEL = 2'd3; DIN = 4'b1100; START = 1'b1;
    tick; START = 1'b0; outs("s3_k1", 4'b1010, 1'b1, 1'b0);
    tick; START = 1'b1; DIN = 4'b1111; SEL = 2'd0; outs("s3_k2", 4'b1010, 1'b1, 1'b0);
    tick; START = 1'b0; outs("s3_k3", 4'b1010, 1'b1, 1'b0);
    tick; outs("s3_k4", 4'b1001, 1'b0, 1'b1);
    tick; outs("s3_after1", 4'b1001, 1'b0, 1'b0);
    tick; outs("s3_after2", 4'b1001, 1'b0, 1'b0);

    // Back-to-back with START held through DONE.
    SEL = 2'd2; DIN = 4'b0110; START = 1'b1;
    tick; outs("bb_k1", 4'b1001, 1'b1, 1'b0);
    tick; outs("bb_k2", 4'b1001, 1'b1, 1'b0);
    tick; outs("bb_k3", 4'b1001, 1'b0, 1'b1);
    SEL = 2'd1; DIN = 4'b0011;
    tick; START = 1'b0; outs("bb_k4", 4'b1001, 1'b1, 1'b0);
    tick; outs("bb_k5", 4'b1001, 1'b0, 1'b1);
    tick;

    // Reset in the middle of a SEL=3 command: no DONE, outputs zero.
    SEL = 2'd3; DIN = 4'b0101; START = 1'b1;
    tick; START = 1'b0; RST = 1'b1; outs("mr_k1", 4'b1001, 1'b1, 1'b0);
    tick; RST = 1'b0; outs("mr_rst", 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick; outs("mr_quiet", 4'h0, 1'b0, 1'b0);
    end

    // Round trip: feed bs(SEL, x) = rotl(x, SEL), expect x back.
    for (int s = 0; s < 4; s++) begin
      for (int x = 1; x < 16; x += 5) begin
        SEL = 2'(s); DIN = 4'(rotl4(x, s)); START = 1'b1;
        tick; START = 1'b0;
        got = int'(DONE);
        for (int c = 0; c < 6 && got == 0; c++) begin
          tick; got = int'(DONE);
        end
        check("rt_done", got, 1);
        if (got != 0) check("rt_value", {28'd0, DOUT}, x);
      end
    end
    tick;

`ifdef BSR_DIR_EN
    // Left rotation: DIR=1, SEL=2, DIN=1001 -> 0110.
    dir_t = 1'b1; SEL = 2'd2; DIN = 4'b1001; START = 1'b1;
    tick; START = 1'b0;
    tick;
    tick; outs("dl2", 4'b0110, 1'b0, 1'b1);
    tick;
    dir_t = 1'b0; START = 1'b1;
    tick; START = 1'b0;
    tick;
    tick; outs("dr2", 4'b0110, 1'b0, 1'b1);
    tick;
    dir_t = 1'b1; SEL = 2'd1; START = 1'b1;
    tick; START = 1'b0;
    tick; outs("dl1", 4'b0011, 1'b0, 1'b1);
    tick;
    dir_t = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsr_seq.md
# bsr_seq

Sequential 4-bit right-rotate unit: the inverse of the combinational left barrel rotator `bs`. It accepts a rotated word and the rotate amount `SEL`, then rotates the word right by one bit per clock until the original word is recovered. A START/BUSY/DONE handshake sequences it, so it can sit behind `bs` in a datapath or bench and undo its rotation. The result is registered and held until the next accepted command.

## Interface
- `WIDTH`, default 4: data width. Must equal 2**`SELW`.
- `SELW`, default 2: width of the rotate amount.
- `CLK` input 1: the single clock; all state changes on the rising edge.
- `RST` input 1: synchronous, active-high reset; sampled on the rising edge of `CLK`.
- `START` input 1: command strobe; sampled only in IDLE and DONE.
- `SEL` input `SELW`: rotate-right amount, 0..WIDTH-1; captured with START.
- `DIN` input `WIDTH`: word to rotate; captured with START.
- `DIR` input 1: direction; present only with `BSR_DIR_EN`.
- `DOUT` output `WIDTH`: registered result; held between commands.
- `BUSY` output 1: high while rotation steps are in progress (SHIFT state).
- `DONE` output 1: one-cycle pulse; `DOUT` is valid in the same cycle.

## Operation
- Internal state:
  - working register `W[WIDTH-1:0]`
  - down-counter `CNT[SELW-1:0]`
  - FSM with states IDLE, SHIFT, DONE.
- IDLE:
  - START=1 → W←DIN, CNT←SEL.
  - Next state is SHIFT if SEL≠0, else DONE.
  - START=0 → stay in IDLE.
- SHIFT, each cycle:
  - W←{W[0], W[WIDTH-1:1]} (rotate right by 1).
  - CNT←CNT-1.
  - When CNT==1 on entry to this cycle, the next state is DONE and DOUT←rotated W.
- DONE, one cycle, DONE=1:
  - START=1 → accepted exactly as in IDLE (back-to-back commands allowed).
  - Otherwise → IDLE.
- START in SHIFT is ignored; it is not queued.
- SEL=0 case: DOUT←DIN on the transition to DONE, and no SHIFT cycles occur.
- DOUT changes only on entry to DONE. It holds its value through IDLE, SHIFT and any later commands until the next DONE.
- Result: DOUT = DIN rotated right by SEL mod WIDTH. For any X, feeding `bs` output for (SEL, X) returns X.

## Timing
- Reset values:
  - DOUT=0, BUSY=0, DONE=0.
  - FSM=IDLE, W=0, CNT=0.
- RST is asserted mid-operation: the next edge forces all reset values, the command is lost, and DONE is not pulsed. RST has priority over START.
- Latency: START sampled at edge k → DONE=1 and DOUT valid during cycle k+SEL+1.
  - SEL=0 gives 1 cycle; SEL=3 gives 4 cycles.
- BUSY=1 for exactly SEL cycles (cycles k+1 .. k+SEL). BUSY=0 in IDLE and DONE.
- Throughput: with START held high in DONE, a new command starts every SEL+1 cycles.
- CNT never wraps. SEL=0 bypasses SHIFT, so CNT is never decremented from 0.

## Configuration
- `BSR_DIR_EN` defined:
  - Adds the `DIR` input, captured with START.
  - DIR=0: rotate right (default behaviour).
  - DIR=1: rotate left one bit per cycle, W←{W[WIDTH-2:0], W[WIDTH-1]}, which matches `bs` forward mapping.
  - Latency and handshake are unchanged.
- `BSR_DIR_EN` undefined:
  - There is no `DIR` port and the unit rotates right only.
  - Port list is otherwise identical.

## Test plan
- Reset: hold RST=1 for 2 cycles with START=1 → DOUT=0000, BUSY=0, DONE=0 throughout. FSM accepts nothing until RST=0.
- SEL=01, DIN=0011, START at edge k → BUSY=1 in cycle k+1 only; DONE=1 at k+2 with DOUT=1001.
- SEL=00, DIN=1010 → DONE=1 at k+1 with DOUT=1010; BUSY never asserted.
- SEL=11, DIN=1100 → BUSY for 3 cycles and DONE at k+4 with DOUT=1001. A START with DIN=1111 at k+2 is ignored; DOUT remains 1001 afterwards.
- Back-to-back: START held high with SEL=10, DIN=0110 then SEL=01, DIN=0011 → DOUT=1001 at k+3, then DOUT=1001 again at k+5. RST pulsed at k+1 of a further SEL=11 command → outputs zero and no DONE.
- With `BSR_DIR_EN`: DIR=1, SEL=10, DIN=1001 → DONE at k+3 with DOUT=0110. DIR=0 with the same inputs → DOUT=0110 as well (half rotation). DIR=1, SEL=01, DIN=1001 → DOUT=0011.
